bram_port_client: RTL

Single-clock client controller that owns one port of a synchronous, read-first block RAM: the 16-bit × 1024-entry true-dual-port RAM the team infers for Xilinx BRAM. It turns a valid/ready request stream (reads and writes) into RAM port strobes (en/we/addr/di). It captures the RAM's one-cycle-latency read data (do) into a 3-entry response FIFO drained by a valid/ready response channel. A built-in sequencer can sweep the whole array to a constant, either after reset or on command.

---
 rtl/bram_port_client_if.sv | 31 +++
 rtl/bram_port_client.sv | 134 +++++++++++++
 2 files changed

// File: rtl/bram_port_client_if.sv
// rtl/bram_port_client_if.sv - request/response channels and RAM port strobes of bram_port_client
interface bram_port_client_if #(
  parameter int AW = 10,
  parameter int DW = 16
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] rsp_addr;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_di;
  logic [DW-1:0] ram_do;

  // Environment side: request producer, response consumer and the RAM itself.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_do,
    input  req_ready, rsp_valid, rsp_rdata, rsp_addr, ram_en, ram_we, ram_addr, ram_di
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_do,
    output req_ready, rsp_valid, rsp_rdata, rsp_addr, ram_en, ram_we, ram_addr, ram_di
  );
endinterface

// File: rtl/bram_port_client.sv
// rtl/bram_port_client.sv - one-port client of a read-first BRAM with response FIFO and clear sweep
module bram_port_client #(
  parameter int            AW         = 10,
  parameter int            DW         = 16,
  parameter logic [DW-1:0] CLR_VAL    = '0,
  parameter bit            INIT_CLEAR = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  bram_port_client_if.slave bus,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done
);
  typedef enum logic {ST_SERVE, ST_CLEAR} state_t;

  localparam state_t        RESET_STATE = INIT_CLEAR ? ST_CLEAR : ST_SERVE;
  localparam logic [AW-1:0] LAST_ADDR   = {AW{1'b1}};

  state_t        state_q, state_d;
  logic [AW-1:0] clr_addr_q;
  logic          clr_done_q;
  logic          pend_q;
  logic [AW-1:0] tag_q;
  logic [1:0]    occ_q, occ_d;
  logic [1:0]    wr_idx;
  logic [DW-1:0] dat_q [3];
  logic [DW-1:0] dat_d [3];
  logic [AW-1:0] adr_q [3];
  logic [AW-1:0] adr_d [3];
  logic          accept;
  logic          credit_ok;
  logic          push;
  logic          pop;

  // Credits count both stored entries and the read whose data lands next cycle,
  // so req_ready never depends on rsp_ready.
  assign credit_ok = ({1'b0, occ_q} + {2'b00, pend_q}) < 3'd3;
  assign push      = pend_q;
  assign pop       = (occ_q != 2'd0) && bus.rsp_ready;

  assign bus.rsp_valid = (occ_q != 2'd0);
  assign bus.rsp_rdata = dat_q[0];
  assign bus.rsp_addr  = adr_q[0];
  assign clr_done      = clr_done_q;

  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = bus.req_addr;
    bus.ram_di    = bus.req_wdata;
    clr_busy      = 1'b0;
    accept        = 1'b0;
    case (state_q)
      ST_SERVE: begin
        if (clr_start) begin
          state_d = ST_CLEAR;
        end else begin
          bus.req_ready = credit_ok;
          accept        = bus.req_valid && credit_ok;
          bus.ram_en    = accept;
          bus.ram_we    = accept && bus.req_we;
        end
      end
      ST_CLEAR: begin
        clr_busy     = 1'b1;
        bus.ram_en   = 1'b1;
        bus.ram_we   = 1'b1;
        bus.ram_addr = clr_addr_q;
        bus.ram_di   = CLR_VAL;
        if (clr_addr_q == LAST_ADDR) begin
          state_d = ST_SERVE;
        end
      end
    endcase
    // Keep the RAM port quiet for the whole time reset is held.
    if (!rst_n) begin
      bus.req_ready = 1'b0;
      bus.ram_en    = 1'b0;
      bus.ram_we    = 1'b0;
      accept        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RESET_STATE;
      clr_addr_q <= '0;
      clr_done_q <= 1'b0;
      pend_q     <= 1'b0;
      tag_q      <= '0;
      occ_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      clr_done_q <= (state_q == ST_CLEAR) && (state_d == ST_SERVE);
      clr_addr_q <= (state_q == ST_CLEAR) ? clr_addr_q + 1'b1 : '0;
      pend_q     <= accept && !bus.req_we;
      if (accept && !bus.req_we) begin
        tag_q <= bus.req_addr;
      end
      occ_q <= occ_d;
    end
  end

  // Shift FIFO: entry 0 is always the head, so the response outputs come straight from flops.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      dat_d[i] = dat_q[i];
      adr_d[i] = adr_q[i];
    end
    wr_idx = occ_q;
    if (pop) begin
      dat_d[0] = dat_q[1];
      dat_d[1] = dat_q[2];
      adr_d[0] = adr_q[1];
      adr_d[1] = adr_q[2];
      wr_idx   = occ_q - 2'd1;
    end
    if (push && (wr_idx != 2'd3)) begin
      dat_d[wr_idx] = bus.ram_do;
      adr_d[wr_idx] = tag_q;
    end
    occ_d = occ_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      dat_q[i] <= dat_d[i];
      adr_q[i] <= adr_d[i];
    end
  end
endmodule
